computer_mc: RTL

- Parametrised multi-cycle successor to the single-cycle 8-bit A/B accumulator computer.
- Keeps the A/B register pair, the K-immediate instruction format and the Z/N/C/V status flags.
- Replaces the combinational instruction and data memory paths with req/ack handshake ports, so memories may take any number of cycles.
- Adds a fetch/execute/memory FSM, a run gate, a halt instruction and illegal-opcode detection.

---
 rtl/computer_mc.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/computer_mc.sv
// computer_mc: multi-cycle A/B accumulator computer with req/ack instruction
// and data memory ports, a run gate, HLT and illegal-opcode detection.
//
// Handshake: a request (imem_req / dmem_req) is held high with its address
// and write fields stable until the cycle in which the matching ack is
// sampled high at a rising edge; that edge completes the transfer. An ack
// seen while the request is low is ignored.
module computer_mc #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int OP_W   = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [OP_W+DATA_W-1:0] imem_data,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DATA_W-1:0]      dmem_addr,
  output logic [DATA_W-1:0]      dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [DATA_W-1:0]      dmem_rdata,
  output logic [DATA_W-1:0]      reg_a,
  output logic [DATA_W-1:0]      reg_b,
  output logic [PC_W-1:0]        pc_out,
  output logic [DATA_W-1:0]      alu_out,
  output logic [3:0]             flags,
  output logic                   halted,
  output logic                   illegal
);

  localparam int MSB = DATA_W - 1;

  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(8'h00);
  localparam logic [OP_W-1:0] OP_LDA  = OP_W'(8'h01);
  localparam logic [OP_W-1:0] OP_LDB  = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_MAB  = OP_W'(8'h03);
  localparam logic [OP_W-1:0] OP_MBA  = OP_W'(8'h04);
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(8'h05);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'(8'h06);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'(8'h07);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'(8'h08);
  localparam logic [OP_W-1:0] OP_XOR  = OP_W'(8'h09);
  localparam logic [OP_W-1:0] OP_ADDK = OP_W'(8'h0A);
  localparam logic [OP_W-1:0] OP_SUBK = OP_W'(8'h0B);
  localparam logic [OP_W-1:0] OP_LDK  = OP_W'(8'h0C);
  localparam logic [OP_W-1:0] OP_STK  = OP_W'(8'h0D);
  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(8'h0E);
  localparam logic [OP_W-1:0] OP_STI  = OP_W'(8'h0F);
  localparam logic [OP_W-1:0] OP_CMP  = OP_W'(8'h10);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(8'h11);
  localparam logic [OP_W-1:0] OP_JEQ  = OP_W'(8'h12);
  localparam logic [OP_W-1:0] OP_JNE  = OP_W'(8'h13);
  localparam logic [OP_W-1:0] OP_JLT  = OP_W'(8'h14);
  localparam logic [OP_W-1:0] OP_JCS  = OP_W'(8'h15);
  localparam logic [OP_W-1:0] OP_HLT  = OP_W'(8'h7F);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t                   state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [DATA_W-1:0]        a_q, a_d, b_q, b_d;
  logic [OP_W+DATA_W-1:0]   ir_q, ir_d;
  logic [3:0]               flags_q, flags_d;
  logic                     pend_q, pend_d;

  logic [OP_W-1:0]          op;
  logic [DATA_W-1:0]        k;
  logic [DATA_W-1:0]        opnd;
  logic [DATA_W:0]          sum_w, dif_w;
  logic                     alu_c, alu_v, alu_fl;
  logic [3:0]               alu_flags;
  logic [PC_W-1:0]          pc_inc, jmp_tgt;
  logic                     is_store;

  assign op        = ir_q[OP_W+DATA_W-1:DATA_W];
  assign k         = ir_q[DATA_W-1:0];
  assign pc_inc    = pc_q + PC_W'(1);
  assign jmp_tgt   = PC_W'(k);
  assign is_store  = (op == OP_STK) || (op == OP_STI);
  assign alu_flags = {alu_out == '0, alu_out[MSB], alu_c, alu_v};

  // A pending fetch keeps its request up even if run falls; reset drops it at once.
  assign imem_req   = rst_n && (state_q == S_FETCH) && (run || pend_q);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = dmem_req && is_store;
  assign dmem_addr  = ((op == OP_LDI) || (op == OP_STI)) ? b_q : k;
  assign dmem_wdata = a_q;
  assign reg_a      = a_q;
  assign reg_b      = b_q;
  assign pc_out     = pc_q;
  assign flags      = flags_q;
  assign halted     = (state_q == S_HALT);

  // ALU: result and candidate flags for the instruction held in IR.
  always_comb begin
    opnd    = ((op == OP_ADDK) || (op == OP_SUBK)) ? k : b_q;
    sum_w   = {1'b0, a_q} + {1'b0, opnd};
    dif_w   = {1'b0, a_q} - {1'b0, opnd};
    alu_out = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_fl  = 1'b0;
    case (op)
      OP_ADD, OP_ADDK: begin
        alu_out = sum_w[MSB:0];
        alu_c   = sum_w[DATA_W];
        alu_v   = (a_q[MSB] == opnd[MSB]) && (sum_w[MSB] != a_q[MSB]);
        alu_fl  = 1'b1;
      end
      OP_SUB, OP_SUBK, OP_CMP: begin
        alu_out = dif_w[MSB:0];
        alu_c   = dif_w[DATA_W];  // borrow: A < operand
        alu_v   = (a_q[MSB] != opnd[MSB]) && (dif_w[MSB] != a_q[MSB]);
        alu_fl  = 1'b1;
      end
      OP_AND: begin alu_out = a_q & b_q; alu_fl = 1'b1; end
      OP_OR:  begin alu_out = a_q | b_q; alu_fl = 1'b1; end
      OP_XOR: begin alu_out = a_q ^ b_q; alu_fl = 1'b1; end
      OP_LDA, OP_LDB: alu_out = k;
      OP_MAB: alu_out = b_q;
      OP_MBA: alu_out = a_q;
      default: ;
    endcase
  end

  // Next-state, register writeback and the illegal pulse.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    pend_d  = pend_q;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_req) begin
          if (imem_ack) begin
            ir_d    = imem_data;
            pend_d  = 1'b0;
            state_d = S_EXEC;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      S_EXEC: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
        if (alu_fl) flags_d = alu_flags;
        case (op)
          OP_NOP, OP_CMP: ;
          OP_LDA, OP_MAB, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_ADDK, OP_SUBK: a_d = alu_out;
          OP_LDB, OP_MBA: b_d = alu_out;
          OP_LDK, OP_STK, OP_LDI, OP_STI: begin
            pc_d    = pc_q;
            state_d = S_MEM;
          end
          OP_JMP: pc_d = jmp_tgt;
          OP_JEQ: if (flags_q[3])  pc_d = jmp_tgt;
          OP_JNE: if (!flags_q[3]) pc_d = jmp_tgt;
          OP_JLT: if (flags_q[2])  pc_d = jmp_tgt;
          OP_JCS: if (flags_q[1])  pc_d = jmp_tgt;
          OP_HLT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: illegal = 1'b1;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (!is_store) a_d = dmem_rdata;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      pend_q  <= pend_d;
    end
  end

endmodule
